// File: rtl/chime_scheduler.sv
// Buzzer arbiter for the digital clock: hourly chime (N beeps) and a
// repeating alarm pattern share one registered buzzer output.
module chime_scheduler #(
  parameter int BEEP_ON     = 200,
  parameter int BEEP_GAP    = 300,
  parameter int ALM_ON      = 500,
  parameter int ALM_OFF     = 500,
  parameter int ALM_PERIODS = 60
) (
  input  logic       clk_1kHz,
  input  logic       rst,
  input  logic [3:0] h_cntH,
  input  logic [3:0] h_cntL,
  input  logic [3:0] m_cntH,
  input  logic [3:0] m_cntL,
  input  logic [3:0] s_cntH,
  input  logic [3:0] s_cntL,
  input  logic [3:0] al_hH,
  input  logic [3:0] al_hL,
  input  logic [3:0] al_mH,
  input  logic [3:0] al_mL,
  input  logic       chime_en,
  input  logic       alarm_en,
  input  logic       stop,
  output logic       buzzer,
  output logic       chime_act,
  output logic       alarm_act
);

  localparam logic [9:0] BEEP_END = 10'(BEEP_ON - 1);
  localparam logic [9:0] GAP_END  = 10'(BEEP_GAP - 1);
  localparam logic [9:0] AON_END  = 10'(ALM_ON - 1);
  localparam logic [9:0] AOFF_END = 10'(ALM_OFF - 1);
  localparam logic [5:0] PERIODS  = 6'(ALM_PERIODS);

  typedef enum logic [2:0] {stIdle, stChimeOn, stChimeGap, stAlmOn, stAlmOff} state_t;

  state_t     state;
  logic [9:0] ph;
  logic [3:0] beepCnt;
  logic [5:0] periodCnt;
  logic       valid;
  logic [3:0] prevSL;
  logic       newSec;
  logic       chimeReq;
  logic       alarmReq;
  logic [4:0] hourBin;
  logic [3:0] beepNum;

  assign newSec   = valid && (s_cntL != prevSL);
  assign chimeReq = chime_en && newSec && ({m_cntH, m_cntL} == 8'h00) && ({s_cntH, s_cntL} == 8'h00);
  assign alarmReq = alarm_en && newSec && ({h_cntH, h_cntL} == {al_hH, al_hL}) &&
                    ({m_cntH, m_cntL} == {al_mH, al_mL}) && ({s_cntH, s_cntL} == 8'h00);

  // 12-hour beep count: midnight rings 12, afternoon hours fold down by 12
  assign hourBin = 5'(h_cntH) * 5'd10 + 5'(h_cntL);
  always_comb begin
    beepNum = hourBin[3:0];
    if (hourBin == 5'd0)
      beepNum = 4'd12;
    else if (hourBin > 5'd12)
      beepNum = 4'(hourBin - 5'd12);
  end

  always_ff @(posedge clk_1kHz) begin
    prevSL <= s_cntL;
    if (rst) begin
      state     <= stIdle;
      ph        <= '0;
      beepCnt   <= '0;
      periodCnt <= '0;
      valid     <= 1'b0;
      buzzer    <= 1'b0;
      chime_act <= 1'b0;
      alarm_act <= 1'b0;
    end else begin
      valid <= 1'b1;
      ph    <= ph + 10'd1;
      case (state)
        stIdle: begin
          if (alarmReq) begin
            state     <= stAlmOn;
            ph        <= '0;
            periodCnt <= '0;
            alarm_act <= 1'b1;
            buzzer    <= 1'b0;
          end else if (chimeReq) begin
            state     <= stChimeOn;
            ph        <= '0;
            beepCnt   <= beepNum;
            chime_act <= 1'b1;
            buzzer    <= 1'b0;
          end
        end
        stChimeOn, stChimeGap: begin
          if (stop) begin
            state     <= stIdle;
            buzzer    <= 1'b0;
            chime_act <= 1'b0;
          end else if (alarmReq) begin
            // alarm pre-empts the chime; the remaining beeps are discarded
            state     <= stAlmOn;
            ph        <= '0;
            periodCnt <= '0;
            chime_act <= 1'b0;
            alarm_act <= 1'b1;
            buzzer    <= 1'b0;
          end else if (state == stChimeOn) begin
            if (ph == BEEP_END) begin
              buzzer  <= 1'b0;
              ph      <= '0;
              beepCnt <= beepCnt - 4'd1;
              if (beepCnt == 4'd1) begin
                state     <= stIdle;
                chime_act <= 1'b0;
              end else begin
                state <= stChimeGap;
              end
            end else begin
              buzzer <= ~buzzer;
            end
          end else if (ph == GAP_END) begin
            state <= stChimeOn;
            ph    <= '0;
          end
        end
        stAlmOn, stAlmOff: begin
          if (stop) begin
            state     <= stIdle;
            buzzer    <= 1'b0;
            alarm_act <= 1'b0;
          end else if (state == stAlmOn) begin
            if (ph == AON_END) begin
              state  <= stAlmOff;
              ph     <= '0;
              buzzer <= 1'b0;
            end else if (!ph[0]) begin
              buzzer <= ~buzzer;
            end
          end else if (ph == AOFF_END) begin
            ph        <= '0;
            periodCnt <= periodCnt + 6'd1;
            if (periodCnt + 6'd1 == PERIODS) begin
              state     <= stIdle;
              alarm_act <= 1'b0;
            end else begin
              state <= stAlmOn;
            end
          end
        end
        default: begin
          state     <= stIdle;
          buzzer    <= 1'b0;
          chime_act <= 1'b0;
          alarm_act <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chime_scheduler.sv
// Scoreboard bench: stimulus queues expected activity episodes, a monitor
// measures each chime/alarm episode (length, buzzer pulses, first-high cycle).
`timescale 1ns/1ps
module tb_chime_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] hH, hL, mH, mL, sH, sL;
  logic [3:0] aHH, aHL, aMH, aML;
  logic       chimeEn, alarmEn, stop;
  logic       buzzer, chimeAct, alarmAct;

  chime_scheduler dut (
    .clk_1kHz (clk),
    .rst      (rst),
    .h_cntH   (hH),
    .h_cntL   (hL),
    .m_cntH   (mH),
    .m_cntL   (mL),
    .s_cntH   (sH),
    .s_cntL   (sL),
    .al_hH    (aHH),
    .al_hL    (aHL),
    .al_mH    (aMH),
    .al_mL    (aML),
    .chime_en (chimeEn),
    .alarm_en (alarmEn),
    .stop     (stop),
    .buzzer   (buzzer),
    .chime_act(chimeAct),
    .alarm_act(alarmAct)
  );

  typedef struct {
    int kind;    // 0 chime, 1 alarm
    int cycles;
    int pulses;
    int first;
  } ep_t;

  ep_t expQ[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  protoErr = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic setTime(input int h, input int m, input int s);
    hH = 4'(h / 10); hL = 4'(h % 10);
    mH = 4'(m / 10); mL = 4'(m % 10);
    sH = 4'(s / 10); sL = 4'(s % 10);
  endtask

  task automatic setAlarm(input int h, input int m);
    aHH = 4'(h / 10); aHL = 4'(h % 10);
    aMH = 4'(m / 10); aML = 4'(m % 10);
  endtask

  task automatic waitCyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushExp(input int k, input int c, input int p, input int f);
    ep_t e;
    e.kind = k; e.cycles = c; e.pulses = p; e.first = f;
    expQ.push_back(e);
  endtask

  // monitor: one episode = contiguous run of chime_act or alarm_act
  bit   inEp = 1'b0;
  int   epKind, epCycles, epPulses, epFirst;
  logic prevBuz = 1'b0;

  always @(negedge clk) begin
    ep_t e;
    if (inEp) begin
      if ((epKind == 0 && chimeAct) || (epKind == 1 && alarmAct)) begin
        epCycles++;
        if (buzzer && !prevBuz) epPulses++;
        if (buzzer && epFirst == 0) epFirst = epCycles;
      end else begin
        inEp = 1'b0;
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_episode: got kind=%0d cycles=%0d pulses=%0d, expected none",
                   epKind, epCycles, epPulses);
        end else begin
          e = expQ.pop_front();
          if (e.kind != epKind || e.cycles != epCycles || e.pulses != epPulses || e.first != epFirst) begin
            miscompares++;
            $display("FAIL episode: got kind=%0d cycles=%0d pulses=%0d first=%0d, expected kind=%0d cycles=%0d pulses=%0d first=%0d",
                     epKind, epCycles, epPulses, epFirst, e.kind, e.cycles, e.pulses, e.first);
          end else begin
            $display("episode kind=%0d cycles=%0d pulses=%0d first=%0d ok",
                     epKind, epCycles, epPulses, epFirst);
          end
        end
      end
    end
    if (!inEp && (chimeAct || alarmAct)) begin
      inEp     = 1'b1;
      epKind   = alarmAct ? 1 : 0;
      epCycles = 1;
      epPulses = buzzer ? 1 : 0;
      epFirst  = buzzer ? 1 : 0;
    end
    if ((buzzer && !chimeAct && !alarmAct) || (chimeAct && alarmAct)) protoErr++;
    prevBuz = buzzer;
  end

  initial begin
    rst = 1'b1; stop = 1'b0;
    chimeEn = 1'b1; alarmEn = 1'b0;
    setAlarm(7, 0);
    setTime(5, 0, 0);
    waitCyc(3);
    check("reset_buzzer", buzzer, 0);
    check("reset_chime_act", chimeAct, 0);
    check("reset_alarm_act", alarmAct, 0);
    rst = 1'b0;
    waitCyc(20);
    check("no_chime_after_reset_release", chimeAct, 0);

    // 3 o'clock: 3 beeps
    setTime(2, 59, 59); waitCyc(5);
    pushExp(0, 1200, 300, 2);
    setTime(3, 0, 0); waitCyc(1210);

    // midnight: 12 beeps
    setTime(23, 59, 59); waitCyc(5);
    pushExp(0, 5700, 1200, 2);
    setTime(0, 0, 0); waitCyc(5710);

    // 13:00: single beep
    setTime(12, 59, 59); waitCyc(5);
    pushExp(0, 200, 100, 2);
    setTime(13, 0, 0); waitCyc(210);

    // chime disabled
    chimeEn = 1'b0;
    setTime(13, 59, 59); waitCyc(5);
    setTime(14, 0, 0); waitCyc(3);
    check("chime_disabled_act", chimeAct, 0);
    waitCyc(200);
    chimeEn = 1'b1;

    // full alarm at 07:00, colliding with the top-of-hour chime
    alarmEn = 1'b1;
    setTime(6, 59, 59); waitCyc(5);
    pushExp(1, 60000, 7500, 2);
    setTime(7, 0, 0); waitCyc(1);
    check("alarm_wins_alarm_act", alarmAct, 1);
    check("alarm_wins_chime_act", chimeAct, 0);
    waitCyc(60010);

    // alarm stopped 1700 cycles in
    setTime(6, 59, 59); waitCyc(5);
    pushExp(1, 1700, 250, 2);
    setTime(7, 0, 0); waitCyc(1700);
    stop = 1'b1; waitCyc(1); stop = 1'b0;
    check("stop_buzzer", buzzer, 0);
    check("stop_alarm_act", alarmAct, 0);
    for (int s = 1; s <= 5; s++) begin
      setTime(7, 0, s); waitCyc(5);
    end
    check("no_retrigger_alarm_act", alarmAct, 0);

    // alarm request during CHIME_GAP aborts the chime
    setAlarm(2, 1);
    setTime(1, 59, 59); waitCyc(5);
    pushExp(0, 300, 100, 2);
    pushExp(1, 600, 125, 2);
    setTime(2, 0, 0); waitCyc(251);
    setTime(2, 0, 59); waitCyc(49);
    setTime(2, 1, 0); waitCyc(1);
    check("abort_chime_act", chimeAct, 0);
    check("abort_alarm_act", alarmAct, 1);
    waitCyc(599);
    stop = 1'b1; waitCyc(1); stop = 1'b0;
    waitCyc(10);

    // reset mid-chime (in the first gap)
    setTime(5, 59, 59); waitCyc(5);
    pushExp(0, 450, 100, 2);
    setTime(6, 0, 0); waitCyc(450);
    rst = 1'b1; waitCyc(1);
    check("midreset_buzzer", buzzer, 0);
    check("midreset_chime_act", chimeAct, 0);
    check("midreset_alarm_act", alarmAct, 0);
    rst = 1'b0;
    waitCyc(20);
    check("no_replay_after_reset", chimeAct, 0);

    waitCyc(5);
    check("idle_buzzer_or_overlap", protoErr, 0);
    check("pending_episodes", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chime_scheduler.md
# chime_scheduler

Buzzer scheduler for the digital-clock experiment. It shares the single buzzer output between two requesters: the top-of-hour chime and the user alarm. The chime sounds a short beep once per hour-count (12-hour count). The alarm sounds a repeating on/off pattern for up to 60 s. Time inputs are the BCD counters of the clock core.

## Interface
- `BEEP_ON`, 200: chime beep length, clock cycles (ms)
- `BEEP_GAP`, 300: silence between chime beeps, cycles
- `ALM_ON`, 500: alarm sound phase, cycles
- `ALM_OFF`, 500: alarm silent phase, cycles
- `ALM_PERIODS`, 60: maximum alarm on/off periods before auto-stop
- `clk_1kHz` in 1: sole clock (1 kHz); all logic on its rising edge
- `rst` in 1: synchronous, active-high reset
- `h_cntH`, `h_cntL` in 4 each: hour BCD, 00–23
- `m_cntH`, `m_cntL` in 4 each: minute BCD, 00–59
- `s_cntH`, `s_cntL` in 4 each: second BCD, 00–59
- `al_hH`, `al_hL`, `al_mH`, `al_mL` in 4 each: alarm time BCD (hh:mm)
- `chime_en` in 1: enables the hourly chime
- `alarm_en` in 1: enables the alarm
- `stop` in 1: one-cycle pulse, already debounced; silences the active activity
- `buzzer` out 1: tone output, registered
- `chime_act` out 1: high in the CHIME_ON and CHIME_GAP states
- `alarm_act` out 1: high in the ALM_ON and ALM_OFF states

## Operation
- New-second detect:
  - `prev_sL` registers `s_cntL` every cycle.
  - `new_sec = valid & (s_cntL != prev_sL)`.
  - `valid` is cleared by reset and set on the first cycle after reset, so no trigger fires on the first post-reset cycle.
- Chime request: `chime_en & new_sec & {m}==8'h00 & {s}==8'h00`.
- Alarm request: `alarm_en & new_sec & {h}=={al_h} & {m}=={al_m} & {s}==8'h00`.
- Beep count:
  - `hb = h_cntH*10 + h_cntL`.
  - If `hb == 0`, N = 12; if `hb > 12`, N = `hb - 12`; otherwise N = `hb`.
  - Range 1–12, held in a 4-bit register, latched on chime start.
- States: IDLE, CHIME_ON, CHIME_GAP, ALM_ON, ALM_OFF. A 10-bit phase counter `ph` restarts at 0 on every state entry.
- IDLE:
  - Alarm request goes to ALM_ON.
  - Otherwise a chime request goes to CHIME_ON.
  - Requests arriving in the same cycle: the alarm wins and the chime is dropped, not queued.
- CHIME_ON:
  - Lasts `BEEP_ON` cycles; `buzzer` toggles every cycle (500 Hz).
  - At the end, the remaining-beep count decrements. If it reaches 0, go to IDLE; else go to CHIME_GAP.
- CHIME_GAP: `buzzer` = 0 for `BEEP_GAP` cycles, then go to CHIME_ON.
- ALM_ON:
  - Lasts `ALM_ON` cycles; `buzzer` toggles every 2nd cycle (250 Hz).
  - Then go to ALM_OFF.
- ALM_OFF:
  - `buzzer` = 0 for `ALM_OFF` cycles.
  - The 6-bit period counter then increments. If it equals `ALM_PERIODS`, go to IDLE; else go to ALM_ON.
- Alarm request in CHIME_ON or CHIME_GAP aborts the chime and moves to ALM_ON.
- Chime request during the alarm states is ignored.
- `stop` in any non-IDLE state goes to IDLE on that edge. `stop` in IDLE has no effect.
- After each state exit, the counters for the exited activity hold no significance.

## Timing
- Reset values:
  - state = IDLE; `buzzer`, `chime_act`, `alarm_act` = 0.
  - `ph`, beep count, period count = 0; `valid` = 0.
- Trigger latency:
  - A request seen at edge E changes state at E.
  - `chime_act`/`alarm_act` are high after E.
  - `buzzer` first goes high at edge E+1.
- Chime duration for N beeps: N·`BEEP_ON` + (N−1)·`BEEP_GAP` cycles, with no trailing gap. N = 3 gives 1200 cycles.
- Alarm full duration: `ALM_PERIODS`·(`ALM_ON`+`ALM_OFF`) = 60000 cycles.
- `buzzer` is forced to 0 on the edge that enters IDLE or a GAP/OFF state.
- Reset mid-activity: the next edge returns all outputs to their reset values. The trigger second is not replayed.

## Test plan
- Reset, then set time 03:00:00 (change from 02:59:59), `chime_en`=1:
  - Exactly 3 bursts of 100 `buzzer` periods, 300-cycle gaps.
  - `chime_act` high for 1200 cycles.
- Hours 00:00:00 and 13:00:00:
  - 12 beeps, total 5700 cycles.
  - 1 beep, 200 cycles.
  - `chime_en`=0 gives no activity.
- Alarm 07:00, `alarm_en`=1 and `chime_en`=1, time steps to 07:00:00:
  - `alarm_act`=1, `chime_act` never rises.
  - 250 Hz bursts of 500 cycles; auto-stop after 60000 cycles.
- `stop` pulse 1700 cycles into the alarm: `buzzer`=0 and `alarm_act`=0 the next cycle. No re-trigger while the time remains within 07:00.
- Time held at 05:00:00 through reset release: no chime (`valid` gating). `rst` asserted mid-chime clears all outputs in 1 cycle.
- Alarm forced via stimulus during CHIME_GAP: chime aborts and ALM_ON is entered on the same edge.
